// File: rtl/cache_ctrl_if.sv
// ---------------------------------------------------------------------------
// cache_ctrl_if
// Bundles every handshake/bus signal of the cache controller: the CPU request
// side, the cache-array lookup/fill side and the RAM side.
//   modport master : the controller (cache_ctrl). It consumes CPU requests,
//                    cache-array responses and RAM acks, and drives the
//                    completion, lookup/fill and RAM request signals.
//   modport slave  : the environment (CPU, cache array and RAM models). It
//                    sees the same signals with directions reversed.
// ---------------------------------------------------------------------------
interface cache_ctrl_if #(
    parameter int LINE_W = 512
);
    // CPU side
    logic              cpu_req;
    logic              cpu_we;
    logic [31:0]       cpu_addr;
    logic [LINE_W-1:0] cpu_wdata;
    logic              cpu_done;
    logic [LINE_W-1:0] cpu_rdata;
    logic              cpu_err;
    logic              busy;

    // Cache array side
    logic              c_lookup;
    logic              c_we;
    logic [31:0]       c_addr;
    logic [LINE_W-1:0] c_wdata;
    logic              c_hit;
    logic              c_miss;
    logic              c_dirty;
    logic [31:0]       c_victim_addr;
    logic [LINE_W-1:0] c_victim_data;
    logic [LINE_W-1:0] c_rdata;
    logic              c_fill;
    logic [LINE_W-1:0] c_fill_data;

    // RAM side
    logic              mem_req;
    logic              mem_we;
    logic [31:0]       mem_addr;
    logic [LINE_W-1:0] mem_wdata;
    logic              mem_ack;
    logic [LINE_W-1:0] mem_rdata;

    modport master (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output cpu_done, cpu_rdata, cpu_err, busy,
        output c_lookup, c_we, c_addr, c_wdata,
        input  c_hit, c_miss, c_dirty, c_victim_addr, c_victim_data, c_rdata,
        output c_fill, c_fill_data,
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_ack, mem_rdata
    );

    modport slave (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  cpu_done, cpu_rdata, cpu_err, busy,
        input  c_lookup, c_we, c_addr, c_wdata,
        output c_hit, c_miss, c_dirty, c_victim_addr, c_victim_data, c_rdata,
        input  c_fill, c_fill_data,
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_ack, mem_rdata
    );
endinterface

// File: rtl/cache_ctrl.sv
// ---------------------------------------------------------------------------
// cache_ctrl
// Line-granular cache controller. Takes one CPU line read/write at a time,
// looks it up in the cache array, and on a miss writes back a dirty victim,
// refills the line from RAM, installs it and re-looks it up once. A RAM
// transfer that is not acknowledged within TMO cycles is abandoned and the
// operation completes with an error.
//
// Ports
//   clk, rst : clock (rising edge) and asynchronous active-high reset
//   bus      : cache_ctrl_if.master
//              cpu_*  request / completion (cpu_done, cpu_err, cpu_rdata, busy)
//              c_*    cache array lookup, response and fill
//              mem_*  RAM writeback / refill request and ack
//
// Parameters
//   LINE_W : line and RAM transfer width in bits
//   TMO    : cycles mem_req may stay high without mem_ack before abort
//
// States
//   IDLE    | waiting for cpu_req; also the cpu_done cycle (busy still 1)
//   ISSUE   | c_lookup strobe high for one cycle
//   EVAL    | array response sampled: hit, miss, or no answer
//   WB      | dirty victim written back to RAM
//   FILL    | line read from RAM
//   INSTALL | c_fill strobe high, then re-lookup
//   DONE    | raises cpu_done (and cpu_err) for the following cycle
// ---------------------------------------------------------------------------
module cache_ctrl #(
    parameter int LINE_W = 512,
    parameter int TMO    = 255
) (
    input  logic          clk,
    input  logic          rst,
    cache_ctrl_if.master  bus
);

    localparam int              CNT_W    = $clog2(TMO + 1);
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TMO - 1);

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        EVAL,
        WB,
        FILL,
        INSTALL,
        DONE
    } state_t;

    state_t            state;

    logic              busy_q;
    logic              cpu_done_q;
    logic              cpu_err_q;
    logic [LINE_W-1:0] cpu_rdata_q;

    logic              c_lookup_q;
    logic              c_we_q;
    logic [31:0]       c_addr_q;
    logic [LINE_W-1:0] c_wdata_q;
    logic              c_fill_q;
    logic [LINE_W-1:0] c_fill_data_q;

    logic              mem_req_q;
    logic              mem_we_q;
    logic [31:0]       mem_addr_q;
    logic [LINE_W-1:0] mem_wdata_q;

    logic              retry_q;
    logic              err_q;
    logic [CNT_W-1:0]  tmo_cnt;

    // c_addr/c_we/c_wdata double as the latched request; mem_addr/mem_wdata
    // double as the latched victim during writeback.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            busy_q        <= 1'b0;
            cpu_done_q    <= 1'b0;
            cpu_err_q     <= 1'b0;
            cpu_rdata_q   <= '0;
            c_lookup_q    <= 1'b0;
            c_we_q        <= 1'b0;
            c_addr_q      <= '0;
            c_wdata_q     <= '0;
            c_fill_q      <= 1'b0;
            c_fill_data_q <= '0;
            mem_req_q     <= 1'b0;
            mem_we_q      <= 1'b0;
            mem_addr_q    <= '0;
            mem_wdata_q   <= '0;
            retry_q       <= 1'b0;
            err_q         <= 1'b0;
            tmo_cnt       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    cpu_done_q <= 1'b0;
                    cpu_err_q  <= 1'b0;
                    // busy is still high during the cpu_done cycle, so a
                    // request arriving then is dropped rather than queued.
                    if (busy_q) begin
                        busy_q <= 1'b0;
                    end else if (bus.cpu_req) begin
                        busy_q     <= 1'b1;
                        c_we_q     <= bus.cpu_we;
                        c_wdata_q  <= bus.cpu_wdata;
                        c_addr_q   <= bus.cpu_addr & ~32'h0000_003F;
                        retry_q    <= 1'b0;
                        err_q      <= 1'b0;
                        c_lookup_q <= 1'b1;
                        state      <= ISSUE;
                    end
                end

                ISSUE: begin
                    c_lookup_q <= 1'b0;
                    state      <= EVAL;
                end

                EVAL: begin
                    if (bus.c_hit) begin
                        cpu_rdata_q <= bus.c_rdata;
                        state       <= DONE;
                    end else if (bus.c_miss) begin
                        if (retry_q) begin
                            // Line was just installed yet still misses.
                            err_q <= 1'b1;
                            state <= DONE;
                        end else if (bus.c_dirty) begin
                            mem_req_q   <= 1'b1;
                            mem_we_q    <= 1'b1;
                            mem_addr_q  <= bus.c_victim_addr;
                            mem_wdata_q <= bus.c_victim_data;
                            tmo_cnt     <= '0;
                            state       <= WB;
                        end else begin
                            mem_req_q  <= 1'b1;
                            mem_we_q   <= 1'b0;
                            mem_addr_q <= c_addr_q;
                            tmo_cnt    <= '0;
                            state      <= FILL;
                        end
                    end else begin
                        // Array gave no answer at all.
                        err_q <= 1'b1;
                        state <= DONE;
                    end
                end

                WB: begin
                    if (bus.mem_ack) begin
                        // mem_req drops here; FILL re-raises it one cycle
                        // later, guaranteeing an idle cycle between transfers.
                        mem_req_q <= 1'b0;
                        mem_we_q  <= 1'b0;
                        tmo_cnt   <= '0;
                        state     <= FILL;
                    end else if (tmo_cnt == TMO_LAST) begin
                        mem_req_q <= 1'b0;
                        mem_we_q  <= 1'b0;
                        err_q     <= 1'b1;
                        state     <= DONE;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end

                FILL: begin
                    if (!mem_req_q) begin
                        mem_req_q  <= 1'b1;
                        mem_we_q   <= 1'b0;
                        mem_addr_q <= c_addr_q;
                        tmo_cnt    <= '0;
                    end else if (bus.mem_ack) begin
                        mem_req_q     <= 1'b0;
                        c_fill_data_q <= bus.mem_rdata;
                        c_fill_q      <= 1'b1;
                        state         <= INSTALL;
                    end else if (tmo_cnt == TMO_LAST) begin
                        mem_req_q <= 1'b0;
                        err_q     <= 1'b1;
                        state     <= DONE;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end

                INSTALL: begin
                    c_fill_q   <= 1'b0;
                    retry_q    <= 1'b1;
                    c_lookup_q <= 1'b1;
                    state      <= ISSUE;
                end

                DONE: begin
                    cpu_done_q <= 1'b1;
                    cpu_err_q  <= err_q;
                    state      <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.busy        = busy_q;
    assign bus.cpu_done    = cpu_done_q;
    assign bus.cpu_err     = cpu_err_q;
    assign bus.cpu_rdata   = cpu_rdata_q;
    assign bus.c_lookup    = c_lookup_q;
    assign bus.c_we        = c_we_q;
    assign bus.c_addr      = c_addr_q;
    assign bus.c_wdata     = c_wdata_q;
    assign bus.c_fill      = c_fill_q;
    assign bus.c_fill_data = c_fill_data_q;
    assign bus.mem_req     = mem_req_q;
    assign bus.mem_we      = mem_we_q;
    assign bus.mem_addr    = mem_addr_q;
    assign bus.mem_wdata   = mem_wdata_q;

endmodule

// File: tb/tb_cache_ctrl.sv
// ---------------------------------------------------------------------------
// tb_cache_ctrl
// Directed bench for cache_ctrl. The stimulus process queues what the cache
// array and RAM should see and answer, plus the expected CPU completion. A
// separate negedge process plays array and RAM, and pops/compares the
// completion scoreboard whenever cpu_done appears.
// ---------------------------------------------------------------------------
module tb_cache_ctrl;

    localparam int LW = 512;
    typedef logic [LW-1:0] line_t;

    localparam line_t L_AA = {16{32'hAAAA_AAAA}};
    localparam line_t L_55 = {16{32'h5555_5555}};
    localparam line_t L_W  = {16{32'h1234_5678}};
    localparam line_t L_V  = {16{32'hDEAD_BEEF}};
    localparam line_t L_R  = {16{32'h0F0F_0F0F}};
    localparam line_t L_77 = {16{32'h7777_7777}};
    localparam line_t L_C3 = {16{32'hC3C3_C3C3}};

    typedef struct {
        logic [31:0] addr;
        logic        we;
        line_t       wdata;
        logic        hit;
        logic        miss;
        logic        dirty;
        logic [31:0] vaddr;
        line_t       vdata;
        line_t       rdata;
    } lk_t;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        line_t       wdata;
        int          delay;    // -1: never acknowledge
        line_t       rdata;
    } mm_t;

    typedef struct {
        line_t rdata;
        logic  err;
    } rsp_t;

    logic clk;
    logic rst;

    cache_ctrl_if #(.LINE_W(LW)) bus ();

    cache_ctrl #(.LINE_W(LW), .TMO(255)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    lk_t  lk_q[$];
    mm_t  mm_q[$];
    rsp_t sb_q[$];

    int n_vec = 0;
    int n_bad = 0;

    int done_cnt      = 0;
    int last_done_cyc = 0;
    int accept_cyc    = 0;
    int lookups       = 0;
    int mem_rises     = 0;
    int mreq_run      = 0;
    int last_run      = 0;
    int mreq_fall_cyc = 0;
    int fill_cnt      = 0;
    line_t last_fill  = '0;
    logic  mreq_prev  = 1'b0;

    lk_t  lk_cur;
    logic lk_pend = 1'b0;
    mm_t  m_cur;
    logic m_act   = 1'b0;
    int   m_cnt   = 0;
    rsp_t r_cur;

    task automatic chk(input string name, input line_t act, input line_t exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    task automatic push_lk(input logic [31:0] a, input logic we, input line_t wd,
                           input logic h, input logic m, input logic dt,
                           input logic [31:0] va, input line_t vd, input line_t rd);
        lk_t e;
        e.addr = a; e.we = we; e.wdata = wd; e.hit = h; e.miss = m; e.dirty = dt;
        e.vaddr = va; e.vdata = vd; e.rdata = rd;
        lk_q.push_back(e);
    endtask

    task automatic push_mm(input logic we, input logic [31:0] a, input line_t wd,
                           input int dly, input line_t rd);
        mm_t e;
        e.we = we; e.addr = a; e.wdata = wd; e.delay = dly; e.rdata = rd;
        mm_q.push_back(e);
    endtask

    task automatic push_sb(input line_t rd, input logic err);
        rsp_t e;
        e.rdata = rd; e.err = err;
        sb_q.push_back(e);
    endtask

    // Array, RAM and completion monitor; everything sampled on the falling edge.
    always @(negedge clk) begin
        if (rst) begin
            bus.c_hit   = 1'b0;
            bus.c_miss  = 1'b0;
            bus.c_dirty = 1'b0;
            bus.mem_ack = 1'b0;
            lk_pend     = 1'b0;
            m_act       = 1'b0;
        end else begin
            if (bus.cpu_done) begin
                done_cnt++;
                last_done_cyc = cyc;
                if (sb_q.size() == 0) begin
                    n_vec++; n_bad++;
                    $display("FAIL unexpected_done: got cpu_done=1 at cycle %0d, required none", cyc);
                end else begin
                    r_cur = sb_q.pop_front();
                    chk("cpu_err", line_t'(bus.cpu_err), line_t'(r_cur.err));
                    if (!r_cur.err) chk("cpu_rdata", bus.cpu_rdata, r_cur.rdata);
                end
            end else if (bus.cpu_err) begin
                n_vec++; n_bad++;
                $display("FAIL err_without_done: got cpu_err=1 cpu_done=0 at cycle %0d, required cpu_err=0", cyc);
            end

            if (bus.c_fill) begin
                fill_cnt++;
                last_fill = bus.c_fill_data;
            end

            if (bus.mem_req) begin
                if (!mreq_prev) mem_rises++;
                mreq_run++;
            end else if (mreq_prev) begin
                last_run      = mreq_run;
                mreq_run      = 0;
                mreq_fall_cyc = cyc;
            end
            mreq_prev = bus.mem_req;

            // Cache array: answers during the cycle after the lookup strobe.
            if (lk_pend) begin
                bus.c_hit         = lk_cur.hit;
                bus.c_miss        = lk_cur.miss;
                bus.c_dirty       = lk_cur.dirty;
                bus.c_victim_addr = lk_cur.vaddr;
                bus.c_victim_data = lk_cur.vdata;
                bus.c_rdata       = lk_cur.rdata;
                lk_pend           = 1'b0;
            end else begin
                bus.c_hit   = 1'b0;
                bus.c_miss  = 1'b0;
                bus.c_dirty = 1'b0;
            end
            if (bus.c_lookup) begin
                lookups++;
                if (lk_q.size() == 0) begin
                    n_vec++; n_bad++;
                    $display("FAIL unexpected_lookup: got c_lookup at addr %0h, required none", bus.c_addr);
                    lk_cur.hit = 1'b0; lk_cur.miss = 1'b0; lk_cur.dirty = 1'b0;
                    lk_cur.vaddr = '0; lk_cur.vdata = '0; lk_cur.rdata = '0;
                end else begin
                    lk_cur = lk_q.pop_front();
                    chk("c_addr", line_t'(bus.c_addr), line_t'(lk_cur.addr));
                    chk("c_we", line_t'(bus.c_we), line_t'(lk_cur.we));
                    if (lk_cur.we) chk("c_wdata", bus.c_wdata, lk_cur.wdata);
                end
                lk_pend = 1'b1;
            end

            // RAM: acknowledges delay cycles after first seeing the request.
            if (bus.mem_ack) begin
                bus.mem_ack = 1'b0;
            end else if (bus.mem_req) begin
                if (!m_act) begin
                    if (mm_q.size() == 0) begin
                        n_vec++; n_bad++;
                        $display("FAIL unexpected_mem_req: got mem_req at addr %0h, required none", bus.mem_addr);
                        m_cur.we = 1'b0; m_cur.addr = '0; m_cur.wdata = '0;
                        m_cur.delay = -1; m_cur.rdata = '0;
                    end else begin
                        m_cur = mm_q.pop_front();
                        chk("mem_we", line_t'(bus.mem_we), line_t'(m_cur.we));
                        chk("mem_addr", line_t'(bus.mem_addr), line_t'(m_cur.addr));
                        if (m_cur.we) chk("mem_wdata", bus.mem_wdata, m_cur.wdata);
                    end
                    m_act = 1'b1;
                    m_cnt = 0;
                end
                if (m_cur.delay >= 0 && m_cnt == m_cur.delay) begin
                    bus.mem_ack   = 1'b1;
                    bus.mem_rdata = m_cur.rdata;
                    m_act         = 1'b0;
                end else begin
                    m_cnt++;
                end
            end else begin
                m_act = 1'b0;
            end
        end
    end

    task automatic do_req(input logic we, input logic [31:0] addr, input line_t wd);
        @(negedge clk);
        bus.cpu_req   = 1'b1;
        bus.cpu_we    = we;
        bus.cpu_addr  = addr;
        bus.cpu_wdata = wd;
        @(negedge clk);
        bus.cpu_req = 1'b0;
        accept_cyc  = cyc;
    endtask

    task automatic wait_done(input int target, input int budget);
        int k;
        k = 0;
        while (done_cnt < target && k < budget) begin
            @(negedge clk);
            k++;
        end
        n_vec++;
        if (done_cnt < target) begin
            n_bad++;
            $display("FAIL done_wait: got %0d completions, required %0d within %0d cycles", done_cnt, target, budget);
        end
        repeat (2) @(negedge clk);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1, "watchdog");
    end

    int d0, r0, f0, l0;

    initial begin
        rst = 1'b1;
        bus.cpu_req = 1'b0; bus.cpu_we = 1'b0; bus.cpu_addr = '0; bus.cpu_wdata = '0;
        bus.c_hit = 1'b0; bus.c_miss = 1'b0; bus.c_dirty = 1'b0;
        bus.c_victim_addr = '0; bus.c_victim_data = '0; bus.c_rdata = '0;
        bus.mem_ack = 1'b0; bus.mem_rdata = '0;
        repeat (3) @(negedge clk);
        chk("rst_busy", line_t'(bus.busy), '0);
        chk("rst_cpu_done", line_t'(bus.cpu_done), '0);
        chk("rst_mem_req", line_t'(bus.mem_req), '0);
        chk("rst_c_lookup", line_t'(bus.c_lookup), '0);
        chk("rst_c_fill", line_t'(bus.c_fill), '0);
        chk("rst_c_addr", line_t'(bus.c_addr), '0);
        rst = 1'b0;
        @(negedge clk);

        // Read hit, unaligned address
        push_lk(32'h0000_1040, 1'b0, '0, 1'b1, 1'b0, 1'b0, '0, '0, L_AA);
        push_sb(L_AA, 1'b0);
        d0 = done_cnt; r0 = mem_rises;
        do_req(1'b0, 32'h0000_1047, '0);
        chk("busy_after_accept", line_t'(bus.busy), line_t'(1));
        wait_done(d0 + 1, 20);
        chk("hit_latency", line_t'(last_done_cyc - accept_cyc), line_t'(3));
        chk("hit_no_mem_req", line_t'(mem_rises - r0), '0);
        chk("busy_after_done", line_t'(bus.busy), '0);

        // Clean read miss, refill after 5 cycles, re-lookup hit
        push_lk(32'h0000_1040, 1'b0, '0, 1'b0, 1'b1, 1'b0, '0, '0, '0);
        push_mm(1'b0, 32'h0000_1040, '0, 5, L_55);
        push_lk(32'h0000_1040, 1'b0, '0, 1'b1, 1'b0, 1'b0, '0, '0, L_55);
        push_sb(L_55, 1'b0);
        d0 = done_cnt; r0 = mem_rises; f0 = fill_cnt;
        do_req(1'b0, 32'h0000_1047, '0);
        wait_done(d0 + 1, 60);
        chk("clean_fill_cnt", line_t'(fill_cnt - f0), line_t'(1));
        chk("clean_fill_data", last_fill, L_55);
        chk("clean_mem_reqs", line_t'(mem_rises - r0), line_t'(1));

        // Dirty write miss: writeback, idle gap, refill, install, write re-lookup
        push_lk(32'h0000_1040, 1'b1, L_W, 1'b0, 1'b1, 1'b1, 32'h0002_3040, L_V, '0);
        push_mm(1'b1, 32'h0002_3040, L_V, 3, '0);
        push_mm(1'b0, 32'h0000_1040, '0, 4, L_R);
        push_lk(32'h0000_1040, 1'b1, L_W, 1'b1, 1'b0, 1'b0, '0, '0, L_W);
        push_sb(L_W, 1'b0);
        d0 = done_cnt; r0 = mem_rises; f0 = fill_cnt;
        do_req(1'b1, 32'h0000_1040, L_W);
        wait_done(d0 + 1, 80);
        chk("dirty_mem_reqs", line_t'(mem_rises - r0), line_t'(2));
        chk("dirty_fill_data", last_fill, L_R);
        chk("dirty_queues", line_t'(lk_q.size() + mm_q.size()), '0);

        // Hit and miss together: hit wins, no RAM traffic
        push_lk(32'h0000_2000, 1'b0, '0, 1'b1, 1'b1, 1'b1, 32'h0000_9040, L_V, L_C3);
        push_sb(L_C3, 1'b0);
        d0 = done_cnt; r0 = mem_rises;
        do_req(1'b0, 32'h0000_203F, '0);
        wait_done(d0 + 1, 20);
        chk("hitmiss_latency", line_t'(last_done_cyc - accept_cyc), line_t'(3));
        chk("hitmiss_no_mem", line_t'(mem_rises - r0), '0);

        // Neither hit nor miss: error completion
        push_lk(32'h0000_2400, 1'b0, '0, 1'b0, 1'b0, 1'b0, '0, '0, '0);
        push_sb('0, 1'b1);
        d0 = done_cnt;
        do_req(1'b0, 32'h0000_2400, '0);
        wait_done(d0 + 1, 20);
        chk("noresp_latency", line_t'(last_done_cyc - accept_cyc), line_t'(3));

        // RAM timeout on refill
        push_lk(32'h0000_5000, 1'b0, '0, 1'b0, 1'b1, 1'b0, '0, '0, '0);
        push_mm(1'b0, 32'h0000_5000, '0, -1, '0);
        push_sb('0, 1'b1);
        d0 = done_cnt;
        do_req(1'b0, 32'h0000_5000, '0);
        wait_done(d0 + 1, 400);
        chk("tmo_req_cycles", line_t'(last_run), line_t'(255));
        chk("tmo_done_after_fall", line_t'(last_done_cyc - mreq_fall_cyc), line_t'(1));

        // Reset while writing back: immediate abort, no completion
        push_lk(32'h0000_6000, 1'b1, L_W, 1'b0, 1'b1, 1'b1, 32'h0000_7040, L_V, '0);
        push_mm(1'b1, 32'h0000_7040, L_V, -1, '0);
        d0 = done_cnt;
        do_req(1'b1, 32'h0000_6000, L_W);
        for (int i = 0; i < 20 && !bus.mem_req; i++) @(negedge clk);
        chk("wb_mem_req_up", line_t'(bus.mem_req), line_t'(1));
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("abort_mem_req", line_t'(bus.mem_req), '0);
        chk("abort_busy", line_t'(bus.busy), '0);
        @(negedge clk);
        rst = 1'b0;
        repeat (6) @(negedge clk);
        chk("abort_no_done", line_t'(done_cnt - d0), '0);

        push_lk(32'h0000_8000, 1'b0, '0, 1'b1, 1'b0, 1'b0, '0, '0, L_77);
        push_sb(L_77, 1'b0);
        d0 = done_cnt;
        do_req(1'b0, 32'h0000_8000, '0);
        wait_done(d0 + 1, 20);
        chk("post_abort_latency", line_t'(last_done_cyc - accept_cyc), line_t'(3));

        // Re-lookup miss after fill, with requests pulsed while busy
        push_lk(32'h0000_3000, 1'b0, '0, 1'b0, 1'b1, 1'b0, '0, '0, '0);
        push_mm(1'b0, 32'h0000_3000, '0, 2, L_77);
        push_lk(32'h0000_3000, 1'b0, '0, 1'b0, 1'b1, 1'b0, '0, '0, '0);
        push_sb('0, 1'b1);
        d0 = done_cnt; l0 = lookups;
        do_req(1'b0, 32'h0000_3000, '0);
        bus.cpu_req  = 1'b1;
        bus.cpu_addr = 32'h0000_9000;
        @(negedge clk);
        bus.cpu_req = 1'b0;
        for (int i = 0; i < 60 && !bus.cpu_done; i++) @(negedge clk);
        bus.cpu_req = 1'b1;
        @(negedge clk);
        bus.cpu_req = 1'b0;
        wait_done(d0 + 1, 20);
        repeat (6) @(negedge clk);
        chk("drop_done_cnt", line_t'(done_cnt - d0), line_t'(1));
        chk("drop_lookups", line_t'(lookups - l0), line_t'(2));

        push_lk(32'h0000_9000, 1'b0, '0, 1'b1, 1'b0, 1'b0, '0, '0, L_55);
        push_sb(L_55, 1'b0);
        d0 = done_cnt;
        do_req(1'b0, 32'h0000_9000, '0);
        wait_done(d0 + 1, 20);
        chk("final_sb_empty", line_t'(sb_q.size()), '0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
